// File: rtl/usb_in_scheduler.sv
// Shares the USB packet transmitter between N_EP IN endpoints: STALL/NAK/DATA per IN token, data toggle, commit/rewind.
// Optional: USB_SCHED_SETUP_TOGGLE_EN makes a SETUP token preset the endpoint toggle to DATA1.
module usb_in_scheduler #(
  parameter int unsigned N_EP        = 4,
  parameter int unsigned MAX_PKT     = 64,
  parameter int unsigned ACK_TIMEOUT = 80
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              rx_token_valid_i,
  input  logic [3:0]        rx_pid_i,
  input  logic [3:0]        rx_endp_i,
  input  logic              rx_hs_valid_i,
  input  logic [N_EP-1:0]   ep_valid_i,
  input  logic [8*N_EP-1:0] ep_data_i,
  input  logic [N_EP-1:0]   ep_last_i,
  input  logic [N_EP-1:0]   ep_halt_i,
  output logic [N_EP-1:0]   ep_ready_o,
  output logic [N_EP-1:0]   ep_commit_o,
  output logic [N_EP-1:0]   ep_rewind_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [3:0]        tx_pid_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_nodata_o,
  output logic              tx_last_o,
  output logic [N_EP-1:0]   toggle_o
);

  localparam int unsigned SW = (N_EP > 1) ? $clog2(N_EP) : 1;
  localparam int unsigned CW = $clog2(MAX_PKT + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_HS, S_DATA, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [3:0]        pid_q, pid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [N_EP-1:0]   tog_q, tog_d;
  logic [N_EP-1:0]   commit_q, commit_d;
  logic [N_EP-1:0]   rewind_q, rewind_d;

  logic              tok_in_range;
  logic [SW-1:0]     tok_sel;
  logic              beat;

  assign tok_in_range = 32'(rx_endp_i) < N_EP;
  assign tok_sel      = SW'(rx_endp_i);

  assign tx_pid_o    = pid_q;
  assign toggle_o    = tog_q;
  assign ep_commit_o = commit_q;
  assign ep_rewind_o = rewind_q;

  // Next-state, transmit beat and endpoint handshake decode
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    tog_d       = tog_q;
    commit_d    = '0;
    rewind_d    = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    tx_nodata_o = 1'b0;
    tx_last_o   = 1'b0;
    ep_ready_o  = '0;
    beat        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_token_valid_i && tok_in_range) begin
          if (rx_pid_i == PID_IN) begin
            sel_d = tok_sel;
            if (ep_halt_i[tok_sel]) begin
              state_d = S_HS;
              pid_d   = PID_STALL;
            end else if (!ep_valid_i[tok_sel]) begin
              state_d = S_HS;
              pid_d   = PID_NAK;
            end else begin
              state_d = S_DATA;
              pid_d   = tog_q[tok_sel] ? PID_DATA1 : PID_DATA0;
              cnt_d   = '0;
            end
          end
`ifdef USB_SCHED_SETUP_TOGGLE_EN
          else if (rx_pid_i == PID_SETUP) begin
            tog_d[tok_sel] = 1'b1;
          end
`endif
        end
      end
      S_HS: begin
        tx_valid_o  = 1'b1;
        tx_nodata_o = 1'b1;
        tx_last_o   = 1'b1;
        if (tx_ready_i) state_d = S_IDLE;
      end
      S_DATA: begin
        tx_valid_o = ep_valid_i[sel_q];
        tx_data_o  = ep_data_i[{sel_q, 3'b000} +: 8];
        tx_last_o  = ep_last_i[sel_q] || (cnt_q == CW'(MAX_PKT - 1));
        beat       = tx_valid_o && tx_ready_i;
        if (beat) begin
          ep_ready_o[sel_q] = 1'b1;
          cnt_d             = cnt_q + CW'(1);
          if (tx_last_o) begin
            tmr_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // ACK beats a coincident timeout; any other handshake or token loses the packet
        if (rx_hs_valid_i && rx_pid_i == PID_ACK) begin
          tog_d[sel_q]    = ~tog_q[sel_q];
          commit_d[sel_q] = 1'b1;
          state_d         = S_IDLE;
        end else if (rx_hs_valid_i || rx_token_valid_i ||
                     tmr_q >= TW'(ACK_TIMEOUT - 1)) begin
          rewind_d[sel_q] = 1'b1;
          state_d         = S_IDLE;
        end else if (tmr_q != TW'(ACK_TIMEOUT)) begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      pid_q    <= 4'h0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      tog_q    <= '0;
      commit_q <= '0;
      rewind_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pid_q    <= pid_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      tog_q    <= tog_d;
      commit_q <= commit_d;
      rewind_q <= rewind_d;
    end
  end

endmodule

// File: tb/tb_usb_in_scheduler.sv
// Randomized bench for usb_in_scheduler: endpoint byte sources plus a transaction-level reference model.
module tb_usb_in_scheduler;
  localparam int N_EP = 4;
  localparam int MAX_PKT = 64;
  localparam int ACK_TO = 80;

  localparam logic [3:0] PID_IN = 4'b1001, PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;

  logic clk = 1'b0, rstn_i;
  logic rx_token_valid_i, rx_hs_valid_i, tx_ready_i;
  logic [3:0] rx_pid_i, rx_endp_i;
  logic [N_EP-1:0] ep_valid_i, ep_last_i, ep_halt_i;
  logic [8*N_EP-1:0] ep_data_i;
  logic [N_EP-1:0] ep_ready_o, ep_commit_o, ep_rewind_o, toggle_o;
  logic tx_valid_o, tx_nodata_o, tx_last_o;
  logic [3:0] tx_pid_o;
  logic [7:0] tx_data_o;

  usb_in_scheduler #(.N_EP(N_EP), .MAX_PKT(MAX_PKT), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .rx_token_valid_i(rx_token_valid_i), .rx_pid_i(rx_pid_i),
    .rx_endp_i(rx_endp_i), .rx_hs_valid_i(rx_hs_valid_i), .ep_valid_i(ep_valid_i),
    .ep_data_i(ep_data_i), .ep_last_i(ep_last_i), .ep_halt_i(ep_halt_i), .ep_ready_o(ep_ready_o),
    .ep_commit_o(ep_commit_o), .ep_rewind_o(ep_rewind_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .tx_pid_o(tx_pid_o), .tx_data_o(tx_data_o),
    .tx_nodata_o(tx_nodata_o), .tx_last_o(tx_last_o), .toggle_o(toggle_o));

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] pid; logic [7:0] data; logic nodata; logic last; } beat_t;

  beat_t obs[$];
  logic [8:0] src[N_EP][$];   // {last, data}; the endpoint's pending bytes
  int rd[N_EP];
  bit gap_en, rdy_rand;
  bit model_tog[N_EP];
  int tests = 0, fails = 0;
  int ncyc, n_commit, n_rewind, rewind_cyc, tx_any;
  logic [N_EP-1:0] commit_seen, rewind_seen;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_EP-1:0] model_tog_vec();
    logic [N_EP-1:0] v;
    for (int e = 0; e < N_EP; e++) v[e] = model_tog[e];
    return v;
  endfunction

  task automatic drive_src();
    for (int e = 0; e < N_EP; e++) begin
      if (rd[e] < src[e].size()) begin
        ep_valid_i[e] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        ep_data_i[8*e +: 8] = src[e][rd[e]][7:0];
        ep_last_i[e] = src[e][rd[e]][8];
      end else begin
        ep_valid_i[e] = 1'b0;
        ep_data_i[8*e +: 8] = 8'h00;
        ep_last_i[e] = 1'b0;
      end
    end
  endtask

  task automatic clear_obs();
    obs.delete();
    n_commit = 0; n_rewind = 0; rewind_cyc = -1; ncyc = 0; tx_any = 0;
    commit_seen = '0; rewind_seen = '0;
  endtask

  // Sample at negedge, advance at posedge+1: endpoint sources react to ready/commit/rewind
  task automatic tick();
    logic [N_EP-1:0] rdy, cm, rw;
    @(negedge clk);
    ncyc++;
    if (tx_valid_o) tx_any++;
    if (tx_valid_o && tx_ready_i) obs.push_back({tx_pid_o, tx_data_o, tx_nodata_o, tx_last_o});
    if (ep_commit_o != '0) begin n_commit++; commit_seen = ep_commit_o; end
    if (ep_rewind_o != '0) begin
      n_rewind++; rewind_seen = ep_rewind_o;
      if (rewind_cyc < 0) rewind_cyc = ncyc;
    end
    rdy = ep_ready_o; cm = ep_commit_o; rw = ep_rewind_o;
    @(posedge clk); #1;
    for (int e = 0; e < N_EP; e++) begin
      if (rdy[e]) rd[e]++;
      if (cm[e]) begin
        for (int k = rd[e]; k > 0; k--) void'(src[e].pop_front());
        rd[e] = 0;
      end
      if (rw[e]) rd[e] = 0;
    end
    tx_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    rx_token_valid_i = 1'b0;
    rx_hs_valid_i = 1'b0;
    drive_src();
  endtask

  task automatic push_pkt(int e, int len, logic [7:0] base);
    for (int i = 0; i < len; i++) src[e].push_back({(i == len - 1), 8'(base + i)});
  endtask

  // One IN transaction; resp: 0 ACK, 1 silence, 2 NAK handshake, 3 IN token during wait
  task automatic do_in(int ep, int resp, string tag);
    int kind, nexp, last_at, budget;
    logic [7:0] exp_b[$];
    logic [3:0] exp_pid;
    if (ep >= N_EP) kind = 0;
    else if (ep_halt_i[ep]) kind = 1;
    else if (src[ep].size() == 0) kind = 2;
    else kind = 3;
    if (kind == 3) begin
      for (int i = 0; i < src[ep].size() && i < MAX_PKT; i++) begin
        exp_b.push_back(src[ep][i][7:0]);
        if (src[ep][i][8]) break;
      end
      exp_pid = model_tog[ep] ? PID_DATA1 : PID_DATA0;
    end else exp_pid = (kind == 1) ? PID_STALL : PID_NAK;
    nexp = exp_b.size();

    gap_en = 1'b0; drive_src(); clear_obs();
    rx_token_valid_i = 1'b1; rx_pid_i = PID_IN; rx_endp_i = 4'(ep);
    tick();
    gap_en = 1'b1;

    if (kind == 0) begin
      repeat (10) tick();
      check({tag, " ignored no tx"}, 32'(tx_any), 0);
      check({tag, " ignored no pulse"}, 32'(n_commit + n_rewind), 0);
    end else if (kind != 3) begin
      budget = 60;
      while (obs.size() == 0 && budget > 0) begin tick(); budget--; end
      repeat (3) tick();
      check({tag, " hs beats"}, 32'(obs.size()), 1);
      if (obs.size() > 0) begin
        check({tag, " hs pid"}, 32'(obs[0].pid), 32'(exp_pid));
        check({tag, " hs nodata/last"}, {30'd0, obs[0].nodata, obs[0].last}, 3);
      end
      check({tag, " hs no pulse"}, 32'(n_commit + n_rewind), 0);
    end else begin
      budget = 800;
      while (!(obs.size() > 0 && obs[obs.size()-1].last) && budget > 0) begin tick(); budget--; end
      check({tag, " packet end seen"}, 32'(budget > 0), 1);
      last_at = ncyc;
      check({tag, " beat count"}, 32'(obs.size()), 32'(nexp));
      for (int i = 0; i < obs.size() && i < nexp; i++) begin
        if (obs[i].data !== exp_b[i] || obs[i].pid !== exp_pid || obs[i].nodata !== 1'b0 ||
            obs[i].last !== (i == nexp - 1))
          check($sformatf("%s beat%0d pid/data/nodata/last", tag, i),
                {18'd0, obs[i].pid, obs[i].data, obs[i].nodata, obs[i].last},
                {18'd0, exp_pid, exp_b[i], 1'b0, (i == nexp - 1)});
      end
      tests++;
      if (resp == 0) begin
        repeat ($urandom_range(0, 4)) tick();
        rx_hs_valid_i = 1'b1; rx_pid_i = PID_ACK;
        tick();
      end else if (resp == 2) begin
        repeat ($urandom_range(0, 4)) tick();
        rx_hs_valid_i = 1'b1; rx_pid_i = PID_NAK;
        tick();
      end else if (resp == 3) begin
        repeat ($urandom_range(0, 4)) tick();
        rx_token_valid_i = 1'b1; rx_pid_i = PID_IN; rx_endp_i = 4'd0;
        tick();
      end
      budget = ACK_TO + 20;
      while (n_commit + n_rewind == 0 && budget > 0) begin tick(); budget--; end
      repeat (4) tick();
      if (resp == 0) begin
        check({tag, " commit count"}, 32'(n_commit), 1);
        check({tag, " commit ep"}, 32'(commit_seen), 32'(1 << ep));
        check({tag, " no rewind"}, 32'(n_rewind), 0);
        model_tog[ep] = !model_tog[ep];
      end else begin
        check({tag, " rewind count"}, 32'(n_rewind), 1);
        check({tag, " rewind ep"}, 32'(rewind_seen), 32'(1 << ep));
        check({tag, " no commit"}, 32'(n_commit), 0);
        if (resp == 1)
          check({tag, " timeout latency ok"},
                32'((rewind_cyc - last_at) >= ACK_TO && (rewind_cyc - last_at) <= ACK_TO + 1), 1);
      end
      check({tag, " no tx after packet"}, 32'(obs.size()), 32'(nexp));
    end
    check({tag, " toggles"}, 32'(toggle_o), 32'(model_tog_vec()));
  endtask

  initial begin
    rstn_i = 1'b0; rx_token_valid_i = 0; rx_hs_valid_i = 0; rx_pid_i = 0; rx_endp_i = 0;
    ep_halt_i = '0; tx_ready_i = 1'b1; gap_en = 0; rdy_rand = 0;
    for (int e = 0; e < N_EP; e++) begin rd[e] = 0; model_tog[e] = 0; end
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_valid", 32'(tx_valid_o), 0);
    check("reset pulses/ready", {20'd0, ep_ready_o, ep_commit_o, ep_rewind_o}, 0);
    check("reset toggle/pid", {24'd0, toggle_o, tx_pid_o}, 0);
    rstn_i = 1'b1;
    tick();

    push_pkt(1, 3, 8'hA1);
    do_in(1, 0, "ep1 first");
    push_pkt(1, 2, 8'h10);
    do_in(1, 0, "ep1 second");
    rdy_rand = 1;
    do_in(2, 0, "ep2 nak");
    push_pkt(2, 4, 8'h20);
    ep_halt_i[2] = 1'b1;
    do_in(2, 0, "ep2 stall");
    ep_halt_i[2] = 1'b0;
    push_pkt(3, 5, 8'h30);
    do_in(3, 1, "ep3 timeout");
    do_in(3, 0, "ep3 replay");
    push_pkt(0, 70, 8'h40);
    do_in(0, 0, "ep0 max cut");
    do_in(0, 0, "ep0 remainder");
    do_in(7, 0, "ep7 out of range");
    push_pkt(0, 3, 8'h90);
    do_in(0, 3, "ep0 token in wait");
    do_in(0, 2, "ep0 nak hs");
    do_in(0, 0, "ep0 ack");

    // Asynchronous reset in the middle of a packet
    push_pkt(1, 12, 8'hC0);
    gap_en = 0; drive_src(); clear_obs();
    rx_token_valid_i = 1'b1; rx_pid_i = PID_IN; rx_endp_i = 4'd1;
    tick();
    for (int b = 0; b < 40 && obs.size() < 2; b++) tick();
    rstn_i = 1'b0;
    #1;
    check("midrst tx outputs", {24'd0, tx_valid_o, tx_nodata_o, tx_last_o, tx_pid_o, 1'b0},
          0);
    check("midrst tx_data", 32'(tx_data_o), 0);
    check("midrst ep outputs", {20'd0, ep_ready_o, ep_commit_o, ep_rewind_o}, 0);
    check("midrst toggles", 32'(toggle_o), 0);
    for (int e = 0; e < N_EP; e++) begin model_tog[e] = 0; rd[e] = 0; end
    @(posedge clk); #1;
    rstn_i = 1'b1;
    drive_src();
    tick();
    do_in(1, 0, "ep1 after reset");

    // SETUP preset of the control endpoint toggle
    clear_obs();
    rx_token_valid_i = 1'b1; rx_pid_i = PID_SETUP; rx_endp_i = 4'd0;
    tick();
    repeat (3) tick();
`ifdef USB_SCHED_SETUP_TOGGLE_EN
    model_tog[0] = 1;
`endif
    check("setup no tx", 32'(tx_any), 0);
    check("setup toggles", 32'(toggle_o), 32'(model_tog_vec()));
    push_pkt(0, 4, 8'hE0);
    do_in(0, 0, "ep0 after setup");

    for (int t = 0; t < 50; t++) begin
      int ep;
      ep = $urandom_range(0, 5);
      ep_halt_i = '0;
      if (ep < N_EP) begin
        if ($urandom_range(0, 9) == 0) ep_halt_i[ep] = 1'b1;
        if ($urandom_range(0, 9) < 6) push_pkt(ep, $urandom_range(1, 80), 8'($urandom));
      end
      do_in(ep, $urandom_range(0, 3), $sformatf("rand%0d ep%0d", t, ep));
    end
    ep_halt_i = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_in_scheduler.md
Name: usb_in_scheduler

Overview:
- Device-side scheduler that shares the single USB packet transmitter between N_EP IN endpoints.
- On each IN token decoded by the packet receiver, it does one of three things:
  - answers STALL if the endpoint is halted;
  - answers NAK if the endpoint has no data;
  - otherwise streams one DATA0/DATA1 packet from that endpoint, then waits for the host ACK.
- Owns the per-endpoint data toggle and tells each endpoint source whether to commit or replay its packet.

Parameters:
- N_EP, 4, number of IN endpoints served; endpoint numbers 0..N_EP-1.
- MAX_PKT, 64, maximum data payload in bytes; a packet is cut at this length.
- ACK_TIMEOUT, 80, clk_i cycles to wait for the host handshake after the packet ends.

Ports:
- clk_i  in  1  system clock (48 MHz)
- rstn_i  in  1  asynchronous active-low reset
- rx_token_valid_i  in  1  one-cycle pulse: token decoded
- rx_pid_i  in  4  PID of the received packet
- rx_endp_i  in  4  endpoint field of the token
- rx_hs_valid_i  in  1  one-cycle pulse: handshake packet received (PID on rx_pid_i)
- ep_valid_i  in  N_EP  endpoint byte available
- ep_data_i  in  8*N_EP  endpoint byte; endpoint e uses bits [8e+7:8e]
- ep_last_i  in  N_EP  current byte is the last of the packet
- ep_halt_i  in  N_EP  endpoint halted
- ep_ready_o  out  N_EP  byte consumed this cycle
- ep_commit_o  out  N_EP  one-cycle pulse: packet acknowledged; discard it
- ep_rewind_o  out  N_EP  one-cycle pulse: packet lost; replay it on the next IN
- tx_valid_o  out  1  transmit beat valid
- tx_ready_i  in  1  transmitter accepts the beat
- tx_pid_o  out  4  PID of the packet; stable for the whole packet
- tx_data_o  out  8  payload byte
- tx_nodata_o  out  1  beat is a handshake-only packet (NAK/STALL)
- tx_last_o  out  1  final beat of the packet
- toggle_o  out  N_EP  current data toggle per endpoint

Behaviour:
- Reset (asynchronous, rstn_i low): all outputs 0, toggles 0 (DATA0), state IDLE, counters 0.
- PID encodings:
  - IN = 4'b1001, SETUP = 4'b1101
  - DATA0 = 4'b0011, DATA1 = 4'b1011
  - ACK = 4'b0010, NAK = 4'b1010, STALL = 4'b1110
- State IDLE, on rx_token_valid_i with rx_pid_i = IN; sel = rx_endp_i is latched:
  - sel >= N_EP: ignored, remain IDLE.
  - ep_halt_i[sel] = 1: go to HS with PID STALL.
  - ep_valid_i[sel] = 0: go to HS with PID NAK.
  - Otherwise: go to DATA with PID = toggle[sel] ? DATA1 : DATA0; byte count = 0.
  - Halt has priority over data.
  - Decision is made from input values in the token cycle; the next state is registered.
- HS:
  - Drive tx_valid_o = 1, tx_nodata_o = 1, tx_last_o = 1 until tx_ready_i.
  - Then return to IDLE.
  - Toggle unchanged.
- DATA:
  - tx_valid_o = ep_valid_i[sel]; tx_data_o = byte of sel.
  - tx_last_o = ep_last_i[sel] OR (count == MAX_PKT-1).
  - ep_ready_o[sel] = tx_valid_o & tx_ready_i; other ep_ready_o bits are 0.
  - count increments on each accepted beat.
  - On the accepted last beat: clear the timeout counter, go to WAIT_ACK.
  - If ep_valid_i drops mid-packet, tx_valid_o drops; the scheduler waits and underrun handling belongs to the transmitter.
- WAIT_ACK:
  - rx_hs_valid_i with ACK: toggle[sel] inverts; ep_commit_o[sel] pulses; go to IDLE.
  - Timeout, i.e. ACK_TIMEOUT cycles elapsed with no ACK: ep_rewind_o[sel] pulses; toggle unchanged; go to IDLE.
  - Any other handshake or any token: same as timeout.
  - If ACK and timeout occur in the same cycle, ACK wins.
- Tokens received in HS, DATA or WAIT_ACK are ignored; only the WAIT_ACK case above acts on them.
- Only one endpoint is ever active, so at most one bit of ep_commit_o, ep_rewind_o or ep_ready_o is set.
- Non-IN tokens in IDLE are ignored, except as described under Optional Feature.
- Width rules: count is $clog2(MAX_PKT+1) bits; the timeout counter is $clog2(ACK_TIMEOUT+1) bits and saturates.

Optional Feature:
- Macro: USB_SCHED_SETUP_TOGGLE_EN.
- Defined: a SETUP token in IDLE with rx_endp_i < N_EP sets toggle[rx_endp_i] = 1, so the control data stage starts with DATA1. No transmission occurs.
- Undefined: SETUP is ignored like any other non-IN token; toggles change only on ACK.

Test Plan:
- Reset, endpoint 1 holds a 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3), IN to endp 1, tx_ready_i = 1 -> DATA0 packet with 3 beats and tx_last_o on 0xA3; ACK -> ep_commit_o[1] pulse and toggle_o[1] = 1; second IN to endp 1 -> DATA1.
- IN to endp 2 with ep_valid_i[2] = 0 -> single NAK beat (tx_nodata_o = 1); IN to endp 2 with ep_halt_i[2] = 1 and data present -> STALL; toggle_o unchanged in both cases.
- DATA0 sent, no handshake for 80 cycles -> ep_rewind_o pulses exactly once, toggle stays 0; repeat IN -> DATA0 again.
- Endpoint 0 supplies 70 bytes with no ep_last_i -> packet ends after 64 beats with tx_last_o on beat 64; a second IN sends the remaining 6 bytes with DATA1 after ACK.
- IN to endp 7 (N_EP = 4), and IN to endp 0 during WAIT_ACK -> no tx_valid_o; the WAIT_ACK case produces a rewind.
- USB_SCHED_SETUP_TOGGLE_EN defined, SETUP to endp 0 then IN -> DATA1. Undefined: same sequence -> DATA0.
- rstn_i low mid-packet -> all outputs 0 immediately, toggles 0.
